// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC tap readout block.
//  - state_t   : readout FSM states
//  - FLUSH_CYC : number of cycles spent discarding stale front-end pipeline contents
//  - code_w()  : width of a binary code able to hold 0..n_taps
package tdc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        ACQ   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Matches the tap-to-code_q latency, so that no sample latched before
    // the measurement began reaches the accumulator.
    localparam int FLUSH_CYC = 3;

    function automatic int code_w(input int n_taps);
        return $clog2(n_taps + 1);
    endfunction

endpackage

// File: rtl/tdc_therm2bin.sv
// Combinational thermometer-to-binary converter with bubble correction.
// Ports:
//   therm  in  N_TAPS  thermometer code, bit 0 nearest the launch point
//   code   out CODE_W  number of ones after 3-input majority bubble correction
// The chain is padded with a 1 below bit 0 and a 0 above the top bit, so the
// end taps are judged against the values an ideal thermometer code would have.
module tdc_therm2bin
    import tdc_pkg::*;
#(
    parameter int N_TAPS = 16,
    localparam int CODE_W = code_w(N_TAPS)
) (
    input  logic [N_TAPS-1:0] therm,
    output logic [CODE_W-1:0] code
);

    logic [N_TAPS+1:0] ext;
    logic [N_TAPS-1:0] fixed;

    assign ext = {1'b0, therm, 1'b1};

    always_comb begin
        fixed = '0;
        for (int i = 0; i < N_TAPS; i++) begin
            // ext[i+1] is therm[i]; ext[i] and ext[i+2] are its neighbours.
            fixed[i] = (ext[i] & ext[i+1]) | (ext[i+1] & ext[i+2]) | (ext[i] & ext[i+2]);
        end
    end

    always_comb begin
        code = '0;
        for (int i = 0; i < N_TAPS; i++) begin
            code = code + CODE_W'(fixed[i]);
        end
    end

endmodule

// File: rtl/tdc_tap_readout.sv
// TDC delay-line receive end: synchronises the tap vector, bubble-corrects it,
// converts to a binary delay code and averages 2**AVG_LOG2 codes per measurement.
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   taps         raw delay-line taps (asynchronous to clk)
//   start        request a measurement (honoured in IDLE only)
//   cont         auto-restart after each accepted result
//   meas_valid   result available; held until accepted
//   meas_ready   host accepts when meas_valid && meas_ready on a clk edge
//   meas_avg     floor(sum / 2**AVG_LOG2)
//   meas_min     smallest code in the window
//   meas_max     largest code in the window
//   meas_sat     some code in the window was 0 or N_TAPS
//   busy         high in FLUSH or ACQ
//   fsm_state    current FSM state, for observation
// Handshake: a result transfers on a rising clk edge where meas_valid and
// meas_ready are both high; meas_valid never drops without that transfer and
// the result outputs do not change while meas_valid is high.
module tdc_tap_readout
    import tdc_pkg::*;
#(
    parameter int N_TAPS   = 16,
    parameter int AVG_LOG2 = 4,
    localparam int CODE_W  = code_w(N_TAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_TAPS-1:0] taps,
    input  logic              start,
    input  logic              cont,
    output logic              meas_valid,
    input  logic              meas_ready,
    output logic [CODE_W-1:0] meas_avg,
    output logic [CODE_W-1:0] meas_min,
    output logic [CODE_W-1:0] meas_max,
    output logic              meas_sat,
    output logic              busy,
    output logic [1:0]        fsm_state
);

    localparam int ACC_W = CODE_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0]  SAMPLES   = CNT_W'(1 << AVG_LOG2);
    localparam logic [CODE_W-1:0] CODE_FULL = CODE_W'(N_TAPS);
    localparam logic [1:0]        FLUSH_END = 2'(FLUSH_CYC - 1);

    // ---------------- front end (free running) ----------------
    logic [N_TAPS-1:0] s1, s2;
    logic [CODE_W-1:0] code_c, code_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= '0;
            s2     <= '0;
            code_q <= '0;
        end else begin
            s1     <= taps;
            s2     <= s1;
            code_q <= code_c;
        end
    end

    tdc_therm2bin #(.N_TAPS(N_TAPS)) u_therm2bin (
        .therm (s2),
        .code  (code_c)
    );

    // ---------------- FSM ----------------
    state_t           state, state_nxt;
    logic [1:0]       flush_cnt;
    logic [CNT_W-1:0] cnt;
    logic             enter_flush;
    logic             acq_finish;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = FLUSH;
            FLUSH: if (flush_cnt == FLUSH_END) state_nxt = ACQ;
            ACQ:   if (cnt == SAMPLES) state_nxt = DONE;
            DONE:  if (meas_ready) state_nxt = cont ? FLUSH : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        meas_valid  = (state == DONE);
        busy        = (state == FLUSH) || (state == ACQ);
        fsm_state   = state;
        enter_flush = ((state == IDLE) && start) ||
                      ((state == DONE) && meas_ready && cont);
        acq_finish  = (state == ACQ) && (cnt == SAMPLES);
    end

    // ---------------- accumulation ----------------
    // ACQ folds one code_q per cycle until SAMPLES have been taken; the
    // following ACQ cycle registers the finished window into the outputs,
    // which puts meas_valid 20 edges after the start edge at defaults.
    logic [ACC_W-1:0]  acc;
    logic [CODE_W-1:0] mn, mx;
    logic              sat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt <= '0;
            cnt       <= '0;
            acc       <= '0;
            mn        <= CODE_FULL;
            mx        <= '0;
            sat       <= 1'b0;
        end else if (enter_flush) begin
            flush_cnt <= '0;
            cnt       <= '0;
            acc       <= '0;
            mn        <= CODE_FULL;
            mx        <= '0;
            sat       <= 1'b0;
        end else begin
            if (state == FLUSH) flush_cnt <= flush_cnt + 2'd1;
            if ((state == ACQ) && (cnt != SAMPLES)) begin
                cnt <= cnt + CNT_W'(1);
                acc <= acc + ACC_W'(code_q);
                if (code_q < mn) mn <= code_q;
                if (code_q > mx) mx <= code_q;
                if ((code_q == '0) || (code_q == CODE_FULL)) sat <= 1'b1;
            end
        end
    end

    // Result registers change only on ACQ->DONE, so they are stable while
    // meas_valid is high and keep the last result after acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meas_avg <= '0;
            meas_min <= '0;
            meas_max <= '0;
            meas_sat <= 1'b0;
        end else if (acq_finish) begin
            meas_avg <= acc[ACC_W-1:AVG_LOG2];
            meas_min <= mn;
            meas_max <= mx;
            meas_sat <= sat;
        end
    end

endmodule
